// File: rtl/arb8_enc_if.sv
// arb8_enc bus: requests, enable, ack in; granted index, gvalid, tmo out.
// Ports: en, req[7:0], ack, a0..a2 (index, a0 = LSB), gvalid, tmo.
interface arb8_enc_if;
  logic       en;
  logic [7:0] req;
  logic       ack;
  logic       a0;
  logic       a1;
  logic       a2;
  logic       gvalid;
  logic       tmo;

  modport master (
    output en, req, ack,
    input  a0, a1, a2, gvalid, tmo
  );

  modport slave (
    input  en, req, ack,
    output a0, a1, a2, gvalid, tmo
  );
endinterface

// File: rtl/arb8_enc.sv
// arb8_enc: 8-slot round-robin arbiter with encoded, registered grant.
// Ports: sys_clk, resetl (async low), bus (arb8_enc_if.slave).
// Option ARB8_GRANT_TIMEOUT_EN: force-release a grant after TMO_CYCLES.
module arb8_enc #(
  parameter int unsigned TMO_CYCLES = 15
) (
  input logic       sys_clk,
  input logic       resetl,
  arb8_enc_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [2:0] idx;
  logic [2:0] last;
  logic [2:0] pick;
  logic       hit;

  // First set request searching upward from last+1, wrapping 7 -> 0.
  always_comb begin
    pick = '0;
    hit  = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (!hit && bus.req[last + 3'(i)]) begin
        hit  = 1'b1;
        pick = last + 3'(i);
      end
    end
  end

`ifdef ARB8_GRANT_TIMEOUT_EN
  localparam logic [3:0] TMO_LIM = 4'(TMO_CYCLES - 1);

  logic [3:0] cnt;
  logic       tmo_q;

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state <= IDLE;
      idx   <= '0;
      last  <= 3'd7;
      cnt   <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.en && hit) begin
            state <= BUSY;
            idx   <= pick;
            cnt   <= '0;
          end
        end
        BUSY: begin
          // ack wins over a timeout landing on the same cycle
          if (bus.ack) begin
            state <= IDLE;
            last  <= idx;
          end else if (cnt == TMO_LIM) begin
            state <= IDLE;
            last  <= idx;
            tmo_q <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
      endcase
    end
  end

  assign bus.tmo = tmo_q;
`else
  logic unused_tmo;

  assign unused_tmo = ^4'(TMO_CYCLES);

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state <= IDLE;
      idx   <= '0;
      last  <= 3'd7;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.en && hit) begin
            state <= BUSY;
            idx   <= pick;
          end
        end
        BUSY: begin
          if (bus.ack) begin
            state <= IDLE;
            last  <= idx;
          end
        end
      endcase
    end
  end

  assign bus.tmo = 1'b0;
`endif

  assign bus.a0     = idx[0];
  assign bus.a1     = idx[1];
  assign bus.a2     = idx[2];
  assign bus.gvalid = (state == BUSY);

endmodule

// File: tb/tb_arb8_enc.sv
// Directed bench for arb8_enc.
// Drives after each rising edge, checks 1 time unit later.
module tb_arb8_enc;

  logic sys_clk = 1'b0;
  logic resetl  = 1'b0;
  int   tests   = 0;
  int   fails   = 0;

  arb8_enc_if bus ();

  arb8_enc #(.TMO_CYCLES(4)) dut (
    .sys_clk (sys_clk),
    .resetl  (resetl),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gidx();
    return {5'b0, bus.a2, bus.a1, bus.a0};
  endfunction

  task automatic chk_grant(input string tag,
                           input logic [2:0] slot);
    chk({tag, "_gv"}, {7'b0, bus.gvalid}, 8'd1);
    chk({tag, "_idx"}, gidx(), {5'b0, slot});
  endtask

  initial begin
    bus.en  = 1'b0;
    bus.req = 8'h00;
    bus.ack = 1'b0;

    step();
    step();
    chk("rst_gv", {7'b0, bus.gvalid}, 8'd0);
    chk("rst_idx", gidx(), 8'd0);
    chk("rst_tmo", {7'b0, bus.tmo}, 8'd0);

    resetl  = 1'b1;
    bus.en  = 1'b1;
    bus.req = 8'h01;
    step();
    chk_grant("single_g1", 3'd0);
    bus.ack = 1'b1;
    step();
    chk("single_idle_gv", {7'b0, bus.gvalid}, 8'd0);
    bus.ack = 1'b0;
    step();
    chk_grant("single_g2", 3'd0);

    // ack held high: ignored in IDLE, so grants alternate with IDLE
    bus.req = 8'hFF;
    bus.ack = 1'b1;
    step();
    chk("rr_idle0_gv", {7'b0, bus.gvalid}, 8'd0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_grant($sformatf("rr_g%0d", k), 3'(k));
      step();
      chk($sformatf("rr_idle%0d_gv", k), {7'b0, bus.gvalid}, 8'd0);
    end
    bus.ack = 1'b0;

    // last = 0
    bus.req = 8'h20;
    step();
    chk_grant("wrap_g5", 3'd5);
    bus.req = 8'h21;
    bus.ack = 1'b1;
    step();
    chk("wrap_idle_gv", {7'b0, bus.gvalid}, 8'd0);
    bus.ack = 1'b0;
    step();
    chk_grant("wrap_g0", 3'd0);
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    step();
    chk_grant("wrap_g5b", 3'd5);
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;

    // last = 5
    bus.req = 8'h08;
    step();
    chk_grant("hold_g3", 3'd3);
    bus.req = 8'h00;
    bus.en  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_grant($sformatf("hold_c%0d", k), 3'd3);
    end
`ifndef ARB8_GRANT_TIMEOUT_EN
    for (int k = 0; k < 20; k++) begin
      step();
      chk_grant($sformatf("hold_long%0d", k), 3'd3);
      chk($sformatf("hold_tmo%0d", k), {7'b0, bus.tmo}, 8'd0);
    end
`endif
    bus.ack = 1'b1;
    bus.req = 8'h08;
    step();
    chk("hold_rel_gv", {7'b0, bus.gvalid}, 8'd0);
    bus.ack = 1'b0;
    step();
    chk("en0_gv", {7'b0, bus.gvalid}, 8'd0);
    chk("en0_idx", gidx(), 8'd3);

`ifdef ARB8_GRANT_TIMEOUT_EN
    // last = 3
    bus.en  = 1'b1;
    bus.req = 8'h01;
    step();
    chk_grant("to_g0", 3'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk_grant($sformatf("to_c%0d", k), 3'd0);
      chk($sformatf("to_tmo%0d", k), {7'b0, bus.tmo}, 8'd0);
    end
    step();
    chk("to_gv", {7'b0, bus.gvalid}, 8'd0);
    chk("to_tmo", {7'b0, bus.tmo}, 8'd1);
    step();
    chk_grant("to_regrant", 3'd0);
    chk("to_tmo_clr", {7'b0, bus.tmo}, 8'd0);
    for (int k = 1; k <= 3; k++) step();
    bus.ack = 1'b1;
    step();
    chk("tack_gv", {7'b0, bus.gvalid}, 8'd0);
    chk("tack_tmo", {7'b0, bus.tmo}, 8'd0);
    bus.ack = 1'b0;
    bus.en  = 1'b0;
    step();
`endif

    bus.en  = 1'b1;
    bus.req = 8'h40;
    step();
    chk_grant("arst_g6", 3'd6);
    #2;
    resetl = 1'b0;
    #1;
    chk("arst_gv", {7'b0, bus.gvalid}, 8'd0);
    chk("arst_idx", gidx(), 8'd0);
    chk("arst_tmo", {7'b0, bus.tmo}, 8'd0);
    step();
    chk("arst_hold_gv", {7'b0, bus.gvalid}, 8'd0);
    resetl  = 1'b1;
    bus.req = 8'h41;
    step();
    chk_grant("arst_first", 3'd0);
    chk("arst_first_tmo", {7'b0, bus.tmo}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
